mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the fixed 32-bit MAR/MDR/RAM access path of the multi-cycle datapath. Accepts one load/store request per transaction from the control unit and runs the MOV/MOC handshake against memory. Splits misaligned half/word accesses into two aligned beats, generates byte enables, assembles and sign/zero-extends read data, and flags memory timeouts. Sits between control_unit/MDR and ram.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8; LANES = DATA_WIDTH/8, a power of two
ADDR_WIDTH, 9, byte address width
TIMEOUT, 15, max cycles mem_mov may stay high without mem_moc before error (>=1)

Ports:
main_clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  request strobe, accepted only in IDLE
rw  in  1  1 = read (load), 0 = write (store)
size  in  2  log2 of access bytes: 0 byte, 1 half, 2 word, 3 dword
sign  in  1  reads: 1 sign-extend, 0 zero-extend
addr  in  ADDR_WIDTH  byte address
wdata  in  DATA_WIDTH  store data, right-justified
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse
err  out  1  sticky error, cleared on next accepted start
rdata  out  DATA_WIDTH  extended load result, held until next read completes
mem_mov  out  1  memory operation valid
mem_rw  out  1  1 = read
mem_addr  out  ADDR_WIDTH  aligned byte address, low log2(LANES) bits zero
mem_be  out  LANES  byte enables, lane 0 = bits 7:0
mem_wdata  out  DATA_WIDTH  lane-positioned store data
mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_moc high
mem_moc  in  1  memory operation complete

Behaviour:
- Reset: state IDLE; busy, done, err, mem_mov = 0; rdata, mem_addr, mem_be, mem_wdata = 0; counters cleared. Reset mid-transaction aborts with no done pulse.
- All outputs are registered. Little-endian. n = 1<<size bytes; off = addr mod LANES.
- IDLE: start=1 latches rw, size, sign, addr, wdata; clears err; busy=1. If n > LANES, go ERR directly (no memory access). Otherwise go BEAT1.
- BEAT1: mem_mov=1, mem_addr = addr with low bits cleared, mem_be = lanes off..min(off+n,LANES)-1, mem_wdata byte i at lane off+i.
- mem_moc sampled on rising edge while mem_mov=1. On moc: drop mem_mov next cycle, capture read lanes. If off+n <= LANES go DONE, else GAP.
- GAP: one cycle with mem_mov=0, then BEAT2: mem_addr = beat-1 address + LANES (wraps mod 2^ADDR_WIDTH), mem_be = lanes 0..off+n-LANES-1, remaining store bytes at lane 0 upward. On moc go DONE.
- Read assembly: beat-1 lanes off.. become result bytes 0..; beat-2 lanes 0.. fill the following bytes. Result extended from 8n bits to DATA_WIDTH per sign. Result is written to rdata in the cycle done is pulsed. Writes leave rdata unchanged.
- Timeout: a per-beat counter increments each cycle mem_mov=1 without moc. When it reaches TIMEOUT, drop mem_mov and go ERR.
- DONE/ERR: one cycle. done=1, busy=0 next cycle. ERR also sets err=1. Return to IDLE.
- Latency, zero-wait memory: start at cycle 0 → mem_mov at cycle 1 → done at cycle 2 (aligned). Split access: mov at cycles 1 and 3, done at cycle 4. Each memory wait cycle adds 1.
- start while busy is ignored. Inputs are sampled only on accept.

Test Plan:
- Aligned word read, addr=0x010, mem_rdata=0xDEADBEEF, moc same cycle → mem_be=4'b1111, mem_addr=0x010, done at cycle 2, rdata=0xDEADBEEF.
- Byte read with sign=1, addr=0x013, lane 3=0x80 → mem_be=4'b1000, rdata=0xFFFFFF80. Repeat with sign=0 → rdata=0x00000080.
- Misaligned word write, addr=0x006, wdata=0x11223344:
  - beat 1: mem_addr=0x004, be=4'b1100, mem_wdata=0x33440000
  - GAP cycle with mov low
  - beat 2: mem_addr=0x008, be=4'b0011, mem_wdata=0x00001122
  - done at cycle 4
- Misaligned half read, addr=0x1FF (wrap), beat 1 lane3=0x34, beat 2 lane0=0x12 → second mem_addr=0x000, rdata=0x00001234.
- mem_moc never asserted → mem_mov drops after 15 cycles, done and err=1. Next start clears err. size=3 at DATA_WIDTH=32 → immediate err with mem_mov never asserted.
- reset asserted during BEAT1 wait → next cycle mem_mov=0, busy=0, no done pulse. start during busy → ignored, no extra transaction.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access path with lane split, byte enables and MOV/MOC handshake
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 15
) (
    input  logic                      main_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      rw,
    input  logic [1:0]                size,
    input  logic                      sign,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      mem_mov,
    output logic                      mem_rw,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_moc
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);

    typedef enum logic [2:0] {S_IDLE, S_BEAT1, S_GAP, S_BEAT2, S_DONE, S_ERR} state_t;

    state_t                  state, state_d;
    logic                    busy_d, done_d, err_d, mov_d, mem_rw_d;
    logic [DATA_WIDTH-1:0]   rdata_d, wd_d, wdata_q, wdata_qd, rbuf, rbuf_d;
    logic [ADDR_WIDTH-1:0]   addr_d, addr_q, addr_qd;
    logic [LANES-1:0]        be_d;
    logic                    rw_q, rw_qd, sign_q, sign_qd;
    logic [1:0]              size_q, size_qd;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [DATA_WIDTH-1:0]   asm_v, ext_v;
    int                      off_in, n_in, off_q, n_q, shift, top;

    // lanes lo..hi-1 enabled
    function automatic logic [LANES-1:0] lane_mask(input int lo, input int hi);
        logic [LANES-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++) m[l] = (l >= lo) && (l < hi);
        return m;
    endfunction

    // lane l carries data byte l-shift, only where enabled
    function automatic logic [DATA_WIDTH-1:0] place(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [LANES-1:0] m, input int sh);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++)
            if (m[l]) w[8*l +: 8] = d[8*(l-sh) +: 8];
        return w;
    endfunction

    // merge the current beat's read lanes into the partial result and extend it
    always_comb begin
        off_q = int'(addr_q & LANE_MASK);
        n_q   = 1 << size_q;
        shift = (state == S_BEAT2) ? off_q - LANES : off_q;
        top   = ((n_q > LANES) ? LANES : n_q) * 8 - 1;
        asm_v = rbuf;
        for (int l = 0; l < LANES; l++)
            if (mem_be[l]) asm_v[8*(l-shift) +: 8] = mem_rdata[8*l +: 8];
        ext_v = asm_v;
        for (int k = 0; k < DATA_WIDTH; k++)
            if (k > top) ext_v[k] = sign_q & asm_v[top];
    end

    // next state and next values of every registered output
    always_comb begin
        state_d  = state;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = err;
        rdata_d  = rdata;
        mov_d    = mem_mov;
        mem_rw_d = mem_rw;
        addr_d   = mem_addr;
        be_d     = mem_be;
        wd_d     = mem_wdata;
        rw_qd    = rw_q;
        size_qd  = size_q;
        sign_qd  = sign_q;
        addr_qd  = addr_q;
        wdata_qd = wdata_q;
        rbuf_d   = rbuf;
        cnt_d    = cnt;
        off_in   = int'(addr & LANE_MASK);
        n_in     = 1 << size;
        case (state)
            S_IDLE: if (start) begin
                rw_qd    = rw;
                size_qd  = size;
                sign_qd  = sign;
                addr_qd  = addr;
                wdata_qd = wdata;
                err_d    = 1'b0;
                cnt_d    = '0;
                rbuf_d   = '0;
                if (n_in > LANES) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d  = S_BEAT1;
                    busy_d   = 1'b1;
                    mov_d    = 1'b1;
                    mem_rw_d = rw;
                    addr_d   = addr & ~LANE_MASK;
                    be_d     = lane_mask(off_in, (off_in + n_in > LANES) ? LANES : off_in + n_in);
                    wd_d     = place(wdata, be_d, off_in);
                end
            end
            S_BEAT1, S_BEAT2: begin
                if (mem_moc) begin
                    mov_d  = 1'b0;
                    cnt_d  = '0;
                    rbuf_d = asm_v;
                    if (state == S_BEAT1 && off_q + n_q > LANES) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (rw_q) rdata_d = ext_v;
                    end
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    mov_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_BEAT2;
                mov_d   = 1'b1;
                addr_d  = mem_addr + ADDR_WIDTH'(LANES);
                be_d    = lane_mask(0, off_q + n_q - LANES);
                wd_d    = place(wdata_q, be_d, off_q - LANES);
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // state and output registers, synchronous reset aborts any transaction
    always_ff @(posedge main_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_mov   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rw_q      <= 1'b0;
            size_q    <= '0;
            sign_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf      <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            rdata     <= rdata_d;
            mem_mov   <= mov_d;
            mem_rw    <= mem_rw_d;
            mem_addr  <= addr_d;
            mem_be    <= be_d;
            mem_wdata <= wd_d;
            rw_q      <= rw_qd;
            size_q    <= size_qd;
            sign_q    <= sign_qd;
            addr_q    <= addr_qd;
            wdata_q   <= wdata_qd;
            rbuf      <= rbuf_d;
            cnt       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized bench for mem_access_unit against a byte-array memory model
module tb_mem_access_unit;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int LANES = 4;
    localparam int MSZ = 512;

    logic            main_clk = 1'b0;
    logic            reset, start, rw, sign;
    logic [1:0]      size;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            busy, done, err, mem_mov, mem_rw, mem_moc;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic [LANES-1:0] mem_be;

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
        .main_clk(main_clk), .reset(reset), .start(start), .rw(rw), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    always #5 main_clk = ~main_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]      mem     [MSZ];
    logic [7:0]      ref_mem [MSZ];
    bit              no_moc = 0;
    int              wait_cycles = 0;
    int              mov_cycles = 0;
    int              beat_cnt = 0;
    logic [AW-1:0]   beat_addr [4];
    logic [LANES-1:0] beat_be  [4];
    logic [DW-1:0]   beat_wd   [4];

    // memory responder: completes each beat after wait_cycles, commits writes, logs beats
    initial begin
        int wc;
        wc = 0;
        mem_moc = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge main_clk);
            if (mem_mov && !mem_moc) begin
                mov_cycles++;
                if (!no_moc && wc >= wait_cycles) begin
                    mem_moc = 1'b1;
                    wc = 0;
                    if (beat_cnt < 4) begin
                        beat_addr[beat_cnt] = mem_addr;
                        beat_be[beat_cnt]   = mem_be;
                        beat_wd[beat_cnt]   = mem_wdata;
                    end
                    beat_cnt++;
                    for (int l = 0; l < LANES; l++) begin
                        mem_rdata[8*l +: 8] = mem[int'(mem_addr) + l];
                        if (!mem_rw && mem_be[l]) mem[int'(mem_addr) + l] = mem_wdata[8*l +: 8];
                    end
                end else begin
                    wc++;
                    mem_rdata = $urandom;
                end
            end else begin
                wc = 0;
                mem_moc = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic txn(input bit r, input int sz, input bit sg, input int a,
                       input logic [DW-1:0] wd, input int wt, input bit spurious);
        int n, off, cyc, exp_cyc, nb, b0;
        bit big, split;
        logic [63:0] val;
        n = 1 << sz;
        off = a % LANES;
        big = n > LANES;
        split = !big && (off + n > LANES);
        nb = big ? 0 : (split ? 2 : 1);
        exp_cyc = big ? 1 : 2 + (split ? 2 : 0) + wt * nb;
        val = '0;
        if (!big) begin
            for (int i = 0; i < n; i++) val |= 64'(ref_mem[(a + i) % MSZ]) << (8 * i);
            if (sg && val[8*n-1]) val |= ~((64'd1 << (8 * n)) - 64'd1);
        end
        wait_cycles = wt;
        beat_cnt = 0;
        @(negedge main_clk);
        start = 1'b1; rw = r; size = 2'(sz); sign = sg; addr = AW'(a); wdata = wd;
        @(negedge main_clk);
        cyc = 1;
        start = spurious;
        if (spurious) begin rw = ~r; addr = AW'($urandom); size = 2'd0; end
        if (!big) check("busy_after_accept", busy, 1'b1);
        while (!done && cyc < 100) begin
            @(negedge main_clk);
            start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        check("done_cycle", cyc, exp_cyc);
        check("err", err, big);
        if (r && !big) check("rdata", rdata, val[DW-1:0]);
        check("beats", beat_cnt, nb);
        b0 = a - off;
        for (int b = 0; b < nb && b < beat_cnt; b++) begin
            logic [LANES-1:0] ebe;
            int ba;
            ba = (b0 + b * LANES) % MSZ;
            for (int l = 0; l < LANES; l++) ebe[l] = (((ba + l) - a + MSZ) % MSZ) < n;
            check("beat_addr", beat_addr[b], ba);
            check("beat_be", beat_be[b], ebe);
        end
        if (!r && !big) begin
            for (int i = 0; i < n; i++) ref_mem[(a + i) % MSZ] = wd[8*i +: 8];
            for (int i = 0; i < n; i++) check("wmem", mem[(a + i) % MSZ], ref_mem[(a + i) % MSZ]);
        end
        @(negedge main_clk);
        check("idle_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < MSZ; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        reset = 1'b1; start = 1'b0; rw = 1'b0; size = '0; sign = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge main_clk);
        check("reset_ctrl", {busy, done, err, mem_mov}, 4'b0000);
        check("reset_data", {rdata, mem_addr, mem_be, mem_wdata}, '0);
        reset = 1'b0;

        // aligned word read
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
        for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];
        txn(1, 2, 0, 'h010, '0, 0, 0);
        check("word_rdata", rdata, 32'hDEADBEEF);
        check("word_be", beat_be[0], 4'b1111);

        // byte reads, sign and zero extension
        mem[19] = 8'h80; ref_mem[19] = 8'h80;
        txn(1, 0, 1, 'h013, '0, 0, 0);
        check("byte_sext", rdata, 32'hFFFFFF80);
        check("byte_be", beat_be[0], 4'b1000);
        txn(1, 0, 0, 'h013, '0, 0, 0);
        check("byte_zext", rdata, 32'h00000080);

        // misaligned word write
        txn(0, 2, 0, 'h006, 32'h11223344, 0, 0);
        check("split_wd1", beat_wd[0], 32'h33440000);
        check("split_wd2", beat_wd[1], 32'h00001122);
        check("split_addr2", beat_addr[1], 9'h008);

        // misaligned half read wrapping past the top of memory
        mem[511] = 8'h34; ref_mem[511] = 8'h34; mem[0] = 8'h12; ref_mem[0] = 8'h12;
        txn(1, 1, 0, 'h1FF, '0, 0, 0);
        check("wrap_rdata", rdata, 32'h00001234);
        check("wrap_addr2", beat_addr[1], 9'h000);

        // timeout
        no_moc = 1; mov_cycles = 0;
        @(negedge main_clk);
        start = 1'b1; rw = 1'b1; size = 2'd2; addr = 9'h020;
        @(negedge main_clk);
        start = 1'b0; cyc = 1;
        while (!done && cyc < 100) begin @(negedge main_clk); cyc++; end
        check("timeout_cycle", cyc, 16);
        check("timeout_err", err, 1'b1);
        check("timeout_mov", mov_cycles, 15);
        no_moc = 0;
        @(negedge main_clk);
        txn(1, 2, 0, 'h024, '0, 1, 0);

        // oversize access: immediate error, no memory traffic
        mov_cycles = 0;
        txn(1, 3, 0, 'h040, '0, 0, 0);
        check("oversize_nomov", mov_cycles, 0);

        // start while busy is ignored
        txn(0, 1, 0, 'h05F, 32'h0000BEEF, 1, 1);
        repeat (3) @(negedge main_clk);
        check("spurious_quiet", {mem_mov, done, 32'(beat_cnt)}, {2'b00, 32'd2});

        // reset during a stalled beat
        no_moc = 1;
        @(negedge main_clk);
        start = 1'b1; rw = 1'b1; size = 2'd0; addr = 9'h031;
        @(negedge main_clk);
        start = 1'b0;
        repeat (2) @(negedge main_clk);
        reset = 1'b1;
        @(negedge main_clk);
        reset = 1'b0;
        check("abort_ctrl", {mem_mov, busy, done}, 3'b000);
        cyc = 0;
        repeat (4) begin @(negedge main_clk); if (done) cyc++; end
        check("abort_nodone", cyc, 0);
        no_moc = 0;

        // randomized traffic
        for (int t = 0; t < 40; t++)
            txn($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 1),
                $urandom_range(0, MSZ - 1), $urandom, $urandom_range(0, 2), $urandom_range(0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
